// File: rtl/sn74ls123.sv
// Clocked model of one 74LS123 retriggerable one-shot section.
// Define SN74LS123_INSYNC_EN to add two-flop input synchronizers.
module sn74ls123 #(
   parameter real rT     = 10.0,
   parameter real cT     = 876.2,
   parameter real CLK_NS = 10.0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic clr,
   output logic q,
   output logic q_
);

   localparam real TW     = 0.28 * rT * cT * (1.0 + 0.7 / rT);
   localparam real RATIO  = TW / CLK_NS;
   localparam int  NTRUNC = $rtoi(RATIO);
   localparam int  NCEIL  = (real'(NTRUNC) < RATIO) ? NTRUNC + 1 : NTRUNC;
   localparam int  N      = (NCEIL < 1) ? 1 : NCEIL;
   localparam int  W      = $clog2(N + 1);
   localparam logic [W-1:0] NLOAD = W'(N);

   logic a_s, b_s, clr_s;

`ifdef SN74LS123_INSYNC_EN
   logic [1:0] a_q, b_q, clr_q;

   // Reset values hold the synchronized inputs in the non-trigger state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= 2'b11;
         b_q   <= 2'b00;
         clr_q <= 2'b00;
      end else begin
         a_q   <= {a_q[0], a};
         b_q   <= {b_q[0], b};
         clr_q <= {clr_q[0], clr};
      end
   end

   assign a_s   = a_q[1];
   assign b_s   = b_q[1];
   assign clr_s = clr_q[1];
`else
   assign a_s   = a;
   assign b_s   = b;
   assign clr_s = clr;
`endif

   logic         t, clr_lo, trig;
   logic         t_prev_q;
   logic [W-1:0] cnt_q, cnt_d;

   // Case equality keeps X/Z on any input from forming a trigger.
   assign t      = (clr_s === 1'b1) && (a_s === 1'b0) && (b_s === 1'b1);
   assign clr_lo = (clr_s === 1'b0);
   assign trig   = t && !t_prev_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_lo)
         cnt_d = '0;
      else if (trig)
         cnt_d = NLOAD;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // t_prev resets high so a level already in trigger state cannot fire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         t_prev_q <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         t_prev_q <= t;
      end
   end

   assign q  = (cnt_q != '0);
   assign q_ = ~q;

endmodule

// File: tb/tb_sn74ls123.sv
// Self-checking bench for sn74ls123: directed scenarios plus random
// stimulus against a deadline-based reference model.
module tb_sn74ls123;

   localparam int N = 263;

   logic clk = 1'b0;
   logic rst, a, b, clr;
   logic q, q_;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: absolute cycle at which the pulse ends.
   longint cyc   = 0;
   longint end_c = 0;
   bit     pt    = 1'b1;
   bit     s1a = 1, s2a = 1, s1b = 0, s2b = 0, s1c = 0, s2c = 0;

   sn74ls123 dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .clr (clr),
      .q   (q),
      .q_  (q_)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d",
                  tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      end_c = cyc;
      pt    = 1'b1;
      s1a = 1; s2a = 1; s1b = 0; s2b = 0; s1c = 0; s2c = 0;
   endtask

   task automatic step();
      bit sa, sb, sc, tt;
      @(posedge clk);
      cyc++;
      if (rst) begin
         model_reset();
      end else begin
`ifdef SN74LS123_INSYNC_EN
         sa = s2a; sb = s2b; sc = s2c;
         s2a = s1a; s2b = s1b; s2c = s1c;
         s1a = a;   s1b = b;   s1c = clr;
`else
         sa = a; sb = b; sc = clr;
`endif
         tt = sc && !sa && sb;
         if (!sc)
            end_c = cyc;
         else if (tt && !pt)
            end_c = cyc + N;
         pt = tt;
      end
      #1;
      chk("q", q, (cyc < end_c));
      chk("q_", q_, !(cyc < end_c));
   endtask

   task automatic run(input int n, output int highs);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         step();
         highs += int'(q);
      end
   endtask

   int h, h2, h3;

   initial begin
      rst = 1'b1; a = 1'b1; b = 1'b0; clr = 1'b0;
      #1;
      model_reset();
      chk("rst_q", q, 0);
      chk("rst_q_", q_, 1);
      step(); step();
      rst = 1'b0;

      // clr held low with a=0,b=1: no pulse
      a = 1'b0; b = 1'b1;
      run(1000, h);
      a = 1'b1; step();
      b = 1'b0; step();
      chk("clr_low_hold", h, 0);

      // b rising
      clr = 1'b1; step();
      a = 1'b0;   step();
      b = 1'b1;
      run(300, h);
      chk("b_rise_width", h, N);

      // a falling
      a = 1'b1; step();
      a = 1'b0;
      run(300, h);
      chk("a_fall_width", h, N);

      // clr rising
      clr = 1'b0; step();
      clr = 1'b1;
      run(300, h);
      chk("clr_rise_width", h, N);

      // retrigger on b after 200, on a after another 100
      b = 1'b0; step();
      b = 1'b1;
      run(199, h);
      b = 1'b0; step();
      b = 1'b1;
      run(99, h2);
      a = 1'b1; step();
      a = 1'b0;
      run(400, h3);
      chk("retrig_width", h + h2 + h3 + 2, 200 + 100 + N);

      // clear mid-pulse, then re-fire via clr rising
      a = 1'b1; step();
      a = 1'b0;
      run(50, h);
      chk("pre_clr_high", h, 50);
      clr = 1'b0; step();
      chk("clr_latency", q, 0);
      clr = 1'b1;
      run(300, h);
      chk("clr_refire", h, N);

      // async reset mid-pulse, inputs left in trigger state
      clr = 1'b0; step();
      clr = 1'b1;
      run(100, h);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_q", q, 0);
      chk("async_rst_q_", q_, 1);
      step(); step();
      rst = 1'b0;
      run(300, h);
      chk("no_fire_after_rst", h, 0);

      // random stimulus against the model
      for (int i = 0; i < 6000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 4)
            a = ~a;
         else if (r < 8)
            b = ~b;
         else if (r < 9)
            clr = 1'b0;
         else if (r < 13)
            clr = 1'b1;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
